// File: rtl/rv_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Includes the self-loop branch decoder used for halt detection.
package rv_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT,
        FAULT
    } fetch_state_t;

    localparam logic [6:0]  OPC_BRANCH  = 7'b1100011;
    localparam logic [2:0]  F3_BEQ      = 3'b000;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // A BEQ comparing a register with itself and jumping by zero never leaves its own PC.
    function automatic logic is_self_loop(input logic [31:0] instr);
        return (instr[6:0] == OPC_BRANCH) &&
               (instr[14:12] == F3_BEQ) &&
               (instr[19:15] == instr[24:20]) &&
               (instr[31] == 1'b0) &&
               (instr[30:25] == 6'd0) &&
               (instr[11:8] == 4'd0) &&
               (instr[7] == 1'b0);
    endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready output register between fetch and decode.
// Load wins over flush/accept so a drained entry can be refilled in the same cycle.
module fetch_out_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic            accept,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_pc_plus4,
    input  logic [XLEN-1:0] in_instr,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic [XLEN-1:0] out_instr
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic [XLEN-1:0] instr_q, instr_d;

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        if (load) begin
            valid_d    = 1'b1;
            pc_d       = in_pc;
            pc_plus4_d = in_pc_plus4;
            instr_d    = in_instr;
        end else if (flush || accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            instr_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_pc_plus4 = pc_plus4_q;
    assign out_instr    = instr_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory and feeds decode through fetch_out_reg.
// Handles redirects, misaligned-target faults, self-loop halt and the accepted-instruction count.
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic [XLEN-1:0] out_instr,
    output logic            halted,
    output logic            fault,
    output logic [31:0]     fetch_count
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            fault_q, fault_d;
    logic [31:0]     count_q, count_d;

    logic            load;
    logic            flush;
    logic            accept;
    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = pc_q + INSTR_BYTES;
    assign accept   = (state_q == RUN) && out_valid && out_ready;

    // Priority in RUN: halt on accepted self-loop, then redirect (fault if misaligned), then capture.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        count_d  = count_q;
        load     = 1'b0;
        flush    = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (accept) begin
                    count_d = count_q + 32'd1;
                end
                if (accept && is_self_loop(out_instr)) begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                    flush    = 1'b1;
                end else if (redirect_valid) begin
                    flush = 1'b1;
                    if (redirect_target[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else if (!out_valid || out_ready) begin
                    load = 1'b1;
                    pc_d = pc_plus4;
                end
            end
            HALT:  state_d = HALT;
            FAULT: state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
            count_q  <= count_d;
        end
    end

    fetch_out_reg #(
        .XLEN(XLEN)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .flush       (flush),
        .accept      (accept),
        .in_pc       (pc_q),
        .in_pc_plus4 (pc_plus4),
        .in_instr    (imem_data),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_pc_plus4(out_pc_plus4),
        .out_instr   (out_instr)
    );

    assign imem_addr   = pc_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fetch_count = count_q;

endmodule
